// File: rtl/audioqsys_aud_pkg.sv
// Shared definitions for the audio capture block: register addresses,
// STATUS/CTRL bit positions and the control register layout.
package audioqsys_aud_pkg;

  // Avalon word addresses
  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;

  // STATUS register bit positions (level occupies the low bits)
  localparam int EMPTY_B   = 16;
  localparam int FULL_B    = 17;
  localparam int OVF_B     = 18;
  localparam int UDF_B     = 19;
  localparam int CHIDX_LSB = 24;
  localparam int CHIDX_W   = 3;

  // CTRL register bit positions
  localparam int CTRL_EN_B    = 0;
  localparam int CTRL_IRQEN_B = 1;
  localparam int CTRL_FLUSH_B = 2;
  localparam int CTRL_THR_LSB = 8;

  typedef struct packed {
    logic       enable;
    logic       irq_en;
    logic       flush;
    logic [7:0] thresh;
  } ctrl_t;

endpackage

// File: rtl/audioqsys_aud_fifo.sv
// Synchronous frame FIFO. Supports push and pop in the same cycle (including
// when full), and a flush that empties it and takes priority over a push.
module audioqsys_aud_fifo #(
  parameter  int WIDTH = 48,
  parameter  int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [LVL_W-1:0] level,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty = (r_level == '0);
  assign full  = (r_level == LVL_W'(DEPTH));
  assign level = r_level;
  assign rdata = r_mem[r_rd_ptr];

  // A push into a full FIFO only lands if a pop frees a slot this cycle.
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  // Pointer and level bookkeeping; flush clears everything.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Frame storage write port.
  // NOTE: the array has no reset; slots are only ever read below the level
  // count, so stale contents are never observed and the RAM stays inferable.
  always_ff @(posedge clk) begin
    if (w_do_push && !flush) r_mem[r_wr_ptr] <= wdata;
  end

endmodule

// File: rtl/audioqsys_aud_capture.sv
// Multi-channel audio frame capture with an Avalon-MM slave interface.
// Frames are queued on in_valid and drained one channel per DATA read.
// Optional level/overflow interrupt is built when AUD_CAP_IRQ_EN is defined.
module audioqsys_aud_capture
  import audioqsys_aud_pkg::*;
#(
  parameter  int DATA_W = 24,
  parameter  int CH     = 2,
  parameter  int DEPTH  = 16,
  localparam int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           address,
  input  logic                 read,
  input  logic                 write,
  input  logic [31:0]          writedata,
  output logic [31:0]          readdata,
  input  logic [CH*DATA_W-1:0] in_data,
  input  logic                 in_valid,
  output logic                 irq
);

`ifdef AUD_CAP_IRQ_EN
  localparam logic [7:0] THRESH_RST = 8'(DEPTH / 2);
`else
  localparam logic [7:0] THRESH_RST = 8'd0;
`endif
  localparam ctrl_t CTRL_RST = '{enable: 1'b0, irq_en: 1'b0, flush: 1'b0, thresh: THRESH_RST};

  ctrl_t                r_ctrl;
  logic [31:0]          r_readdata;
  logic [CHIDX_W-1:0]   r_ch_idx;
  logic                 r_ovf;
  logic                 r_udf;

  logic [CH*DATA_W-1:0] w_head;
  logic [LVL_W-1:0]     w_level;
  logic                 w_empty;
  logic                 w_full;
  logic [DATA_W-1:0]    w_chan;
  logic [31:0]          w_rdata;
  logic                 w_rd_data;
  logic                 w_last_ch;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_wr_status;
  logic                 w_wr_ctrl;
  logic                 w_flush;
  logic                 w_unused;

  // Bus decode
  assign w_rd_data   = read & (address == ADDR_DATA);
  assign w_wr_status = write & (address == ADDR_STATUS);
  assign w_wr_ctrl   = write & (address == ADDR_CTRL);
  assign w_flush     = w_wr_ctrl & writedata[CTRL_FLUSH_B];
  assign w_last_ch   = (r_ch_idx == CHIDX_W'(CH - 1));
  assign w_pop       = w_rd_data & ~w_empty & w_last_ch;
  assign w_push      = in_valid & r_ctrl.enable;
  // Undecoded writedata bits are intentionally ignored.
  assign w_unused    = ^writedata;

  audioqsys_aud_fifo #(
    .WIDTH (CH * DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .flush (w_flush),
    .wdata (in_data),
    .rdata (w_head),
    .level (w_level),
    .empty (w_empty),
    .full  (w_full)
  );

  // Select the head frame's channel currently pointed to by the sequencer.
  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_chan = '0;
    for (int k = 0; k < CH; k++) begin
      if (r_ch_idx == CHIDX_W'(k)) w_chan = w_head[k*DATA_W +: DATA_W];
    end
  end

  // Read data multiplexer for the register map.
  always_comb begin
    w_rdata = '0;
    case (address)
      ADDR_DATA: begin
        if (!w_empty) w_rdata = 32'(w_chan);
      end
      ADDR_STATUS: begin
        w_rdata[LVL_W-1:0]                = w_level;
        w_rdata[EMPTY_B]                  = w_empty;
        w_rdata[FULL_B]                   = w_full;
        w_rdata[OVF_B]                    = r_ovf;
        w_rdata[UDF_B]                    = r_udf;
        w_rdata[CHIDX_LSB +: CHIDX_W]     = r_ch_idx;
      end
      ADDR_CTRL: begin
        w_rdata[CTRL_EN_B]                = r_ctrl.enable;
        w_rdata[CTRL_IRQEN_B]             = r_ctrl.irq_en;
        w_rdata[CTRL_FLUSH_B]             = r_ctrl.flush;
        w_rdata[CTRL_THR_LSB +: 8]        = r_ctrl.thresh;
      end
      default: w_rdata = '0;
    endcase
  end

  // Registered read data: updates only on read cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     r_readdata <= '0;
    else if (read) r_readdata <= w_rdata;
  end

  assign readdata = r_readdata;

  // Channel sequencer: advances per non-empty DATA read, wraps on the pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       r_ch_idx <= '0;
    else if (w_flush)                r_ch_idx <= '0;
    else if (w_rd_data && !w_empty)  r_ch_idx <= w_last_ch ? '0 : r_ch_idx + CHIDX_W'(1);
  end

  // Sticky overflow/underflow flags; a new event wins over a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (w_wr_status && writedata[OVF_B]) r_ovf <= 1'b0;
      if (w_wr_status && writedata[UDF_B]) r_udf <= 1'b0;
      if (w_push && w_full && !w_pop && !w_flush) r_ovf <= 1'b1;
      if (w_rd_data && w_empty) r_udf <= 1'b1;
    end
  end

  // Control register; flush is a write-only strobe and never stored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ctrl <= CTRL_RST;
    end else if (w_wr_ctrl) begin
      r_ctrl.enable <= writedata[CTRL_EN_B];
`ifdef AUD_CAP_IRQ_EN
      r_ctrl.irq_en <= writedata[CTRL_IRQEN_B];
      r_ctrl.thresh <= writedata[CTRL_THR_LSB +: 8];
`endif
    end
  end

`ifdef AUD_CAP_IRQ_EN
  logic [7:0] w_thr_eff;
  logic       r_irq;

  // A programmed threshold of zero behaves as one.
  assign w_thr_eff = (r_ctrl.thresh == 8'd0) ? 8'd1 : r_ctrl.thresh;

  // Level interrupt, registered one cycle behind its cause.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_irq <= 1'b0;
    else       r_irq <= r_ctrl.irq_en & ((9'(w_level) >= {1'b0, w_thr_eff}) | r_ovf);
  end

  assign irq = r_irq;
`else
  assign irq = 1'b0;
`endif

endmodule
